multdiv_step_sequencer: RTL

//  Down-counting iteration sequencer for the multdiv unit.
//  - A ctrl_MULT or ctrl_DIV pulse loads a per-operation step count.
//  - The block issues one step_en per cycle until the count reaches zero.
//  - It then raises a one-cycle data_resultRDY.
//  - Sits between the multdiv top level and the multiply/divide datapaths; replaces free-running up-count compare logic.

---
 rtl/multdiv_step_sequencer.sv | 102 ++++++++++
 1 files changed

// File: rtl/multdiv_step_sequencer.sv
// Down-counting iteration sequencer for the multdiv unit: a start pulse loads the
// per-operation step count, one step_en is issued per cycle, then a one-cycle ready.
module multdiv_step_sequencer #(
    parameter int CNT_W      = 6,
    parameter int MULT_STEPS = 16,
    parameter int DIV_STEPS  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             div_by_zero,
    output logic             busy,
    output logic             is_div,
    output logic             step_en,
    output logic             first_step,
    output logic             last_step,
    output logic [CNT_W-1:0] remaining,
    output logic             data_resultRDY,
    output logic             data_exception
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_STEPS - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_STEPS - 1);

    state_t           r_state;
    logic             r_is_div;
    logic [CNT_W-1:0] r_remaining;
    logic             r_first;
    logic             r_exception;
    logic             w_start;

    // Handshake: ctrl_MULT/ctrl_DIV are single-cycle requests accepted unconditionally
    // at any edge (restart semantics); data_resultRDY is a one-cycle valid with no ready.
    assign w_start = ctrl_MULT | ctrl_DIV;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_is_div    <= 1'b0;
            r_remaining <= '0;
            r_first     <= 1'b0;
            r_exception <= 1'b0;
        end else if (w_start) begin
            if (ctrl_MULT) begin
                r_state     <= ST_RUN;
                r_is_div    <= 1'b0;
                r_remaining <= MULT_LOAD;
                r_first     <= 1'b1;
                r_exception <= 1'b0;
            end else if (div_by_zero) begin
                // Divide-by-zero skips the datapath and reports straight away.
                r_state     <= ST_DONE;
                r_is_div    <= 1'b1;
                r_remaining <= '0;
                r_first     <= 1'b0;
                r_exception <= 1'b1;
            end else begin
                r_state     <= ST_RUN;
                r_is_div    <= 1'b1;
                r_remaining <= DIV_LOAD;
                r_first     <= 1'b1;
                r_exception <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_first <= 1'b0;
                    if (r_remaining == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_remaining <= r_remaining - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_exception <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // All outputs decode from registered state only.
    assign busy           = (r_state != ST_IDLE);
    assign is_div         = r_is_div;
    assign step_en        = (r_state == ST_RUN);
    assign first_step     = (r_state == ST_RUN) && r_first;
    assign last_step      = (r_state == ST_RUN) && (r_remaining == '0);
    assign remaining      = r_remaining;
    assign data_resultRDY = (r_state == ST_DONE);
    assign data_exception = (r_state == ST_DONE) && r_exception;

endmodule
